// File: rtl/memory_stage_unit.sv
// MEM stage of the 16-bit pipeline: req/ack data-memory access, upstream stall and the MEM/WB register.
// Optional ACCESS timeout with sticky error flag is built only when MEM_TIMEOUT_EN is defined.
module memory_stage_unit #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_in,
    input  logic              wme_in,
    input  logic              mm_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_out,
    output logic              wbs_out,
    output logic              mm_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic              err_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              wbs_q, wbs_d;
    logic              mm_q, mm_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              memop;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;
`endif

    assign memop      = wme_in | mm_in;
    assign dmem_req   = (state_q == ACCESS);
    assign dmem_we    = dmem_req & wme_in;
    assign dmem_addr  = dmem_req ? alu_result_in : '0;
    assign dmem_wdata = dmem_req ? mem_data_in : '0;

`ifdef MEM_TIMEOUT_EN
    // Timeout fires on the ACCESS cycle whose count would reach TIMEOUT.
    assign timeout = !dmem_ack && ((int'(cnt_q) + 1) >= TIMEOUT);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE && memop) begin
            cnt_d = '0;
        end else if (state_q == ACCESS && !dmem_ack && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == ACCESS && timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

    // MEM/WB loads a bubble by default; only a non-memory op in IDLE or the served op in DONE fill a slot.
    always_comb begin
        state_d   = state_q;
        wbs_d     = 1'b0;
        mm_d      = 1'b0;
        alu_d     = '0;
        rd_d      = '0;
        buf_d     = buf_q;
        stall_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    stall_out = 1'b1;
                    state_d   = ACCESS;
                end else begin
                    wbs_d = wbs_in;
                    mm_d  = mm_in;
                    alu_d = alu_result_in;
                end
            end
            ACCESS: begin
                stall_out = 1'b1;
                if (dmem_ack) begin
                    buf_d   = wme_in ? '0 : dmem_rdata;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    buf_d   = DATA_W'(16'hDEAD);
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                wbs_d   = wbs_in;
                mm_d    = mm_in & ~wme_in;
                alu_d   = alu_result_in;
                rd_d    = buf_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wbs_q   <= 1'b0;
            mm_q    <= 1'b0;
            alu_q   <= '0;
            rd_q    <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            wbs_q   <= wbs_d;
            mm_q    <= mm_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
            buf_q   <= buf_d;
        end
    end

    assign wbs_out        = wbs_q;
    assign mm_out         = mm_q;
    assign alu_result_out = alu_q;
    assign read_data_out  = rd_q;

endmodule

// File: tb/tb_memory_stage_unit.sv
// Scoreboard bench for memory_stage_unit: an upstream driver honours stall_out, a memory model answers
// dmem_req after a programmable latency, and every MEM/WB update is compared against a queue of expected slots.
module tb_memory_stage_unit;

    typedef struct packed {
        logic        wbs;
        logic        mm;
        logic [15:0] alu;
        logic [15:0] rd;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_in = 1'b0;
    logic        wme_in = 1'b0;
    logic        mm_in = 1'b0;
    logic [15:0] alu_result_in = '0;
    logic [15:0] mem_data_in = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_out;
    logic        wbs_out;
    logic        mm_out;
    logic [15:0] alu_result_out;
    logic [15:0] read_data_out;
    logic        err_out;

    int    totalChecks = 0;
    int    badChecks = 0;
    bit    monitorEn = 1'b0;
    slot_t expQ[$];

    int          reqCnt = 0;
    int          ackLat = 0;
    logic        strayAck = 1'b0;
    logic [15:0] mem [0:255] = '{8'h10: 16'hBEEF, default: 16'h0000};

    memory_stage_unit #(.DATA_W(16), .TIMEOUT(15)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wbs_in         (wbs_in),
        .wme_in         (wme_in),
        .mm_in          (mm_in),
        .alu_result_in  (alu_result_in),
        .mem_data_in    (mem_data_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack),
        .stall_out      (stall_out),
        .wbs_out        (wbs_out),
        .mm_out         (mm_out),
        .alu_result_out (alu_result_out),
        .read_data_out  (read_data_out),
        .err_out        (err_out)
    );

    always #5 clk = ~clk;

    // Memory responder: ack on the ackLat-th request cycle (ackLat=0 never acks), plus a stray-ack override.
    assign dmem_ack   = (dmem_req && ackLat > 0 && reqCnt == ackLat - 1) || strayAck;
    assign dmem_rdata = mem[dmem_addr[7:0]];

    always @(posedge clk) begin
        if (!dmem_req || dmem_ack) reqCnt <= 0;
        else reqCnt <= reqCnt + 1;
        if (dmem_req && dmem_ack && dmem_we) mem[dmem_addr[7:0]] <= dmem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Each MEM/WB update is compared against the oldest expected slot.
    always @(posedge clk) begin
        slot_t e;
        #1;
        if (monitorEn && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("memwb", {wbs_out, mm_out, alu_result_out, read_data_out}, e);
        end
    end

    // Drive one op from the EX/MEM side, hold it while stalled, and predict its MEM/WB slots.
    task automatic applyStimulus(input logic wbs, input logic wme, input logic mm,
                                 input logic [15:0] alu, input logic [15:0] wdata,
                                 input int lat, input int accCycles, input logic [15:0] expRd);
        int    stallCnt;
        bit    done;
        bit    isMem;
        slot_t s;
        isMem         = wme | mm;
        wbs_in        = wbs;
        wme_in        = wme;
        mm_in         = mm;
        alu_result_in = alu;
        mem_data_in   = wdata;
        ackLat        = lat;
        s.wbs = wbs;
        s.alu = alu;
        if (isMem) begin
            for (int i = 0; i < 1 + accCycles; i++) expQ.push_back('0);
            s.mm = wme ? 1'b0 : mm;
            s.rd = wme ? 16'h0000 : expRd;
        end else begin
            s.mm = mm;
            s.rd = 16'h0000;
        end
        expQ.push_back(s);
        stallCnt = 0;
        done     = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (stall_out) begin
                stallCnt++;
                if (dmem_req) begin
                    checkOutput("dmemWe", 34'(dmem_we), 34'(wme));
                    checkOutput("dmemAddr", 34'(dmem_addr), 34'(alu));
                    checkOutput("dmemWdata", 34'(dmem_wdata), 34'(wdata));
                end
                @(negedge clk);
            end else begin
                @(negedge clk);
                done = 1'b1;
            end
        end
        if (!done) checkOutput("stallBound", 34'(0), 34'(1));
        checkOutput("stallCycles", 34'(stallCnt), 34'(isMem ? 1 + accCycles : 0));
    endtask

    task automatic pulseReset();
        monitorEn = 1'b0;
        expQ.delete();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstReq", 34'(dmem_req), 34'(0));
        checkOutput("rstRegs", {wbs_out, mm_out, alu_result_out, read_data_out}, 34'(0));
        checkOutput("rstErr", 34'(err_out), 34'(0));
        wbs_in = 1'b0; wme_in = 1'b0; mm_in = 1'b0; alu_result_in = '0; mem_data_in = '0;
        ackLat = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("postRstStall", 34'(stall_out), 34'(0));
        @(negedge clk);
        monitorEn = 1'b1;
    endtask

    initial begin
        #1;
        checkOutput("resetReq", 34'(dmem_req), 34'(0));
        checkOutput("resetRegs", {wbs_out, mm_out, alu_result_out, read_data_out}, 34'(0));
        checkOutput("resetErr", 34'(err_out), 34'(0));
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        monitorEn = 1'b1;

        // ALU op, load with 3-cycle ack, store with same-cycle ack, load of stored data then ALU op.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0042, 16'h0000, 1, 0, 16'h0000);
        checkOutput("errIdle", 34'(err_out), 34'(0));
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 3, 3, 16'hBEEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234, 1, 1, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, 2, 2, 16'h1234);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0077, 16'h0000, 1, 0, 16'h0000);
        // Store and load both requested: store wins.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0030, 16'h5555, 1, 1, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000, 1, 1, 16'h5555);
        // Stray ack outside ACCESS must not disturb an ALU op.
        strayAck = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h00A5, 16'h0000, 1, 0, 16'h0000);
        strayAck = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0101, 16'h0000, 1, 0, 16'h0000);

        // Reset asserted in the middle of an access.
        monitorEn     = 1'b0;
        wbs_in        = 1'b1;
        mm_in         = 1'b1;
        alu_result_in = 16'h0040;
        ackLat        = 0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reqBeforeReset", 34'(dmem_req), 34'(1));
        pulseReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0099, 16'h0000, 1, 0, 16'h0000);

`ifdef MEM_TIMEOUT_EN
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0050, 16'h0000, 0, 15, 16'hDEAD);
        checkOutput("errAfterTimeout", 34'(err_out), 34'(1));
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0051, 16'h0000, 1, 0, 16'h0000);
        checkOutput("errSticky", 34'(err_out), 34'(1));
        pulseReset();
`else
        monitorEn     = 1'b0;
        wbs_in        = 1'b1;
        mm_in         = 1'b1;
        alu_result_in = 16'h0050;
        ackLat        = 0;
        repeat (40) @(negedge clk);
        #1;
        checkOutput("stallForever", 34'(stall_out), 34'(1));
        checkOutput("reqForever", 34'(dmem_req), 34'(1));
        checkOutput("errTiedLow", 34'(err_out), 34'(0));
        pulseReset();
`endif
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1, 1, 16'hBEEF);

        wbs_in = 1'b0; wme_in = 1'b0; mm_in = 1'b0; alu_result_in = '0;
        repeat (2) @(negedge clk);
        checkOutput("queueDrained", 34'(expQ.size()), 34'(0));
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
